// File: rtl/multicycle_control.sv
// Four-state instruction sequencer: accept, decode, wait on the ALU, write back.
// Every output comes straight from a flop so downstream timing stays clean.
module multicycle_control #(
   parameter int OPCODE_W = 6,
   parameter int ALU_OP_W = 3,
   parameter int TIMEOUT  = 16,
   parameter int CNT_W    = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                instr_valid,
   input  logic [OPCODE_W-1:0] opcode,
   output logic                instr_ready,
   output logic [ALU_OP_W-1:0] alu_opcode,
   output logic                alu_start,
   input  logic                alu_done,
   output logic                reg_write_enable,
   output logic                busy,
   output logic                illegal_op,
   output logic                timeout,
   output logic [CNT_W-1:0]    instr_count
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DECODE,
      S_EXEC,
      S_WB
   } state_t;

   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

   state_t              state_q, state_d;
   logic [OPCODE_W-1:0] opcode_q, opcode_d;
   logic [7:0]          wait_q, wait_d;
   logic [ALU_OP_W-1:0] alu_op_q, alu_op_d;
   logic                start_q, start_d;
   logic                we_q, we_d;
   logic                busy_q, busy_d;
   logic                ready_q, ready_d;
   logic                ill_q, ill_d;
   logic                to_q, to_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;

   // Legal opcodes have nothing set above the ALU select field.
   function automatic logic is_legal(input logic [OPCODE_W-1:0] op);
      return (op >> ALU_OP_W) == '0;
   endfunction

   always_comb begin
      state_d  = state_q;
      opcode_d = opcode_q;
      wait_d   = wait_q;
      alu_op_d = alu_op_q;
      start_d  = 1'b0;
      we_d     = 1'b0;
      ill_d    = 1'b0;
      to_d     = 1'b0;
      cnt_d    = cnt_q;

      unique case (state_q)
         S_IDLE: begin
            if (instr_valid) begin
               opcode_d = opcode;
               state_d  = S_DECODE;
               ill_d    = !is_legal(opcode);
            end
         end
         S_DECODE: begin
            if (is_legal(opcode_q)) begin
               alu_op_d = opcode_q[ALU_OP_W-1:0];
               state_d  = S_EXEC;
               start_d  = 1'b1;
               wait_d   = '0;
            end else begin
               alu_op_d = '0;
               state_d  = S_IDLE;
            end
         end
         S_EXEC: begin
            // A late alu_done still beats the timeout on the final cycle.
            if (alu_done) begin
               state_d = S_WB;
               we_d    = 1'b1;
            end else if (wait_q == WAIT_LAST) begin
               state_d = S_IDLE;
               to_d    = 1'b1;
            end else begin
               wait_d = 8'(wait_q + 8'd1);
            end
         end
         S_WB: begin
            state_d = S_IDLE;
            cnt_d   = CNT_W'(cnt_q + 1'b1);
         end
         default: state_d = S_IDLE;
      endcase

      busy_d  = (state_d != S_IDLE);
      ready_d = (state_d == S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         opcode_q <= '0;
         wait_q   <= '0;
         alu_op_q <= '0;
         start_q  <= 1'b0;
         we_q     <= 1'b0;
         busy_q   <= 1'b0;
         ready_q  <= 1'b1;
         ill_q    <= 1'b0;
         to_q     <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         opcode_q <= opcode_d;
         wait_q   <= wait_d;
         alu_op_q <= alu_op_d;
         start_q  <= start_d;
         we_q     <= we_d;
         busy_q   <= busy_d;
         ready_q  <= ready_d;
         ill_q    <= ill_d;
         to_q     <= to_d;
         cnt_q    <= cnt_d;
      end
   end

   assign instr_ready      = ready_q;
   assign alu_opcode       = alu_op_q;
   assign alu_start        = start_q;
   assign reg_write_enable = we_q;
   assign busy             = busy_q;
   assign illegal_op       = ill_q;
   assign timeout          = to_q;
   assign instr_count      = cnt_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed table, random traffic against a
// cycle-offset model, reset abort and counter wrap (CNT_W=4).
module tb_multicycle_control;

   localparam int TMO = 16;

   logic       clk = 1'b0;
   logic       reset;
   logic       instr_valid;
   logic [5:0] opcode;
   logic       instr_ready;
   logic [2:0] alu_opcode;
   logic       alu_start;
   logic       alu_done;
   logic       reg_write_enable;
   logic       busy;
   logic       illegal_op;
   logic       timeout;
   logic [3:0] instr_count;

   multicycle_control #(
      .OPCODE_W(6), .ALU_OP_W(3), .TIMEOUT(TMO), .CNT_W(4)
   ) dut (
      .clk(clk), .reset(reset),
      .instr_valid(instr_valid), .opcode(opcode),
      .instr_ready(instr_ready), .alu_opcode(alu_opcode),
      .alu_start(alu_start), .alu_done(alu_done),
      .reg_write_enable(reg_write_enable), .busy(busy),
      .illegal_op(illegal_op), .timeout(timeout),
      .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   int vecs = 0;
   int errs = 0;
   int exp_cnt = 0;
   int exp_aluop = 0;

   typedef struct {
      int ill_seen;
      int we_n;
      int to_seen;
      int len;
      int aluop;
   } obs_t;

   typedef struct {
      logic [5:0] op;
      int         d;
      int         e_ill;
      int         e_we;
      int         e_to;
      int         e_len;
      int         e_aluop;
   } vec_t;

   task automatic chk(input string nm, input int t,
                      input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s t=%0d: got %0h expected %0h", nm, t, act, exp);
      end
   endtask

   task automatic chk_all(input int t, input int rdy, input int bsy,
                          input int st, input int we, input int ill,
                          input int to, input int aop, input int cnt);
      chk("instr_ready", t, 32'(instr_ready), rdy);
      chk("busy", t, 32'(busy), bsy);
      chk("alu_start", t, 32'(alu_start), st);
      chk("reg_write_enable", t, 32'(reg_write_enable), we);
      chk("illegal_op", t, 32'(illegal_op), ill);
      chk("timeout", t, 32'(timeout), to);
      chk("alu_opcode", t, 32'(alu_opcode), aop);
      chk("instr_count", t, 32'(instr_count), cnt % 16);
   endtask

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   // Expected behaviour is derived from cycle offsets relative to the
   // handshake: decode at +1, EXEC from +2, result or timeout after.
   task automatic run_instr(input logic [5:0] op, input int d,
                            input bit noise, output obs_t o);
      bit legal, done;
      int t_end, x_end, e_rdy, e_bsy, e_st, e_we, e_ill, e_to;
      int e_aop, e_cnt;
      legal = (op < 6'd8);
      done  = legal && (d < TMO);
      if (!legal) begin
         t_end = 2; x_end = 1;
      end else if (done) begin
         t_end = d + 4; x_end = d + 2;
      end else begin
         t_end = TMO + 2; x_end = TMO + 1;
      end
      o = '{0, 0, 0, -1, 0};
      instr_valid = 1'b1;
      opcode      = op;
      alu_done    = noise ? 1'($urandom) : 1'b0;
      @(negedge clk);
      chk("hs_ready", 0, 32'(instr_ready), 1);
      chk("hs_busy", 0, 32'(busy), 0);
      next_cyc();
      for (int t = 1; t <= t_end + 1; t++) begin
         instr_valid = (noise && t < t_end) ? 1'($urandom) : 1'b0;
         opcode      = 6'($urandom);
         if (legal && t >= 2 && t <= x_end)
            alu_done = (t == d + 2);
         else
            alu_done = noise ? 1'($urandom) : 1'b0;
         e_rdy = 0; e_bsy = 1; e_st = 0; e_we = 0;
         e_ill = 0; e_to = 0; e_cnt = exp_cnt;
         e_aop = (t >= 2) ? (legal ? int'(op) % 8 : 0) : exp_aluop;
         if (t == 1) begin
            e_ill = legal ? 0 : 1;
         end else if (t >= t_end) begin
            e_rdy = 1; e_bsy = 0;
            e_to  = (legal && !done && t == t_end) ? 1 : 0;
            e_cnt = exp_cnt + (done ? 1 : 0);
         end else if (t <= x_end) begin
            e_st = (t == 2) ? 1 : 0;
         end else begin
            e_we = 1;
         end
         @(negedge clk);
         chk_all(t, e_rdy, e_bsy, e_st, e_we, e_ill, e_to, e_aop, e_cnt);
         if (illegal_op === 1'b1) o.ill_seen = 1;
         if (reg_write_enable === 1'b1) o.we_n++;
         if (timeout === 1'b1) o.to_seen = 1;
         if (instr_ready === 1'b1 && o.len < 0) o.len = t;
         o.aluop = int'(alu_opcode);
         next_cyc();
      end
      exp_aluop = legal ? int'(op) % 8 : 0;
      if (done) exp_cnt = (exp_cnt + 1) % 16;
   endtask

   vec_t tab[9];
   obs_t ob;

   initial begin
      tab[0] = '{6'b000010, 0,   0, 1, 0, 4,  2};
      tab[1] = '{6'b001000, 0,   1, 0, 0, 2,  0};
      tab[2] = '{6'b000111, 255, 0, 0, 1, 18, 7};
      tab[3] = '{6'b000101, 15,  0, 1, 0, 19, 5};
      tab[4] = '{6'b000011, 14,  0, 1, 0, 18, 3};
      tab[5] = '{6'b111111, 3,   1, 0, 0, 2,  0};
      tab[6] = '{6'b000000, 1,   0, 1, 0, 5,  0};
      tab[7] = '{6'b100001, 0,   1, 0, 0, 2,  0};
      tab[8] = '{6'b000110, 16,  0, 0, 1, 18, 6};

      reset = 1'b1; instr_valid = 1'b0; opcode = '0; alu_done = 1'b0;
      repeat (3) next_cyc();
      @(negedge clk);
      chk_all(-1, 1, 0, 0, 0, 0, 0, 0, 0);
      next_cyc();
      reset = 1'b0;
      @(negedge clk);
      chk_all(-1, 1, 0, 0, 0, 0, 0, 0, 0);
      next_cyc();

      for (int i = 0; i < 9; i++) begin
         run_instr(tab[i].op, tab[i].d, 1'b0, ob);
         chk("tab_ill", i, 32'(ob.ill_seen), tab[i].e_ill);
         chk("tab_we", i, 32'(ob.we_n), tab[i].e_we);
         chk("tab_to", i, 32'(ob.to_seen), tab[i].e_to);
         chk("tab_len", i, 32'(ob.len), tab[i].e_len);
         chk("tab_aluop", i, 32'(ob.aluop), tab[i].e_aluop);
      end

      for (int i = 0; i < 40; i++) begin
         logic [5:0] rop;
         rop = ($urandom_range(0, 3) == 0) ? 6'($urandom)
                                           : 6'($urandom_range(0, 7));
         run_instr(rop, $urandom_range(0, 20), 1'b1, ob);
      end

      // Reset in EXEC with alu_done high: must abort without a write.
      instr_valid = 1'b1; opcode = 6'd5;
      next_cyc();
      instr_valid = 1'b0;
      next_cyc();
      next_cyc();
      reset = 1'b1; alu_done = 1'b1;
      @(negedge clk);
      chk("rst_pre_exec", 3, 32'(busy), 1);
      next_cyc();
      reset = 1'b0; alu_done = 1'b0;
      exp_cnt = 0; exp_aluop = 0;
      @(negedge clk);
      chk_all(4, 1, 0, 0, 0, 0, 0, 0, 0);
      next_cyc();
      @(negedge clk);
      chk_all(5, 1, 0, 0, 0, 0, 0, 0, 0);
      next_cyc();

      for (int i = 0; i < 16; i++) begin
         run_instr(6'(i % 8), 0, 1'b0, ob);
         if (i == 14) chk("cnt_15", i, 32'(instr_count), 15);
      end
      chk("cnt_wrap", 16, 32'(instr_count), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
